// File: rtl/m_bus_arbiter_if.sv
// Bus bundle between the arbiter, the CPU hold handshake, video, blitter and RAM.
// master: arbiter side (drives HOLD, grants, RAM bus, owner); slave: environment side.
interface m_bus_arbiter_if;
    logic        HLDA;
    logic        HOLD;
    logic [19:0] cpuAddr;
    logic        cpuRead;
    logic        cpuWrite;
    logic        vidReq;
    logic [19:0] vidAddr;
    logic        vidGnt;
    logic        blitReq;
    logic [19:0] blitAddr;
    logic        blitRead;
    logic        blitWrite;
    logic        blitWord;
    logic        blitGnt;
    logic [19:0] ABus;
    logic        Read;
    logic        Write;
    logic        Word;
    logic [1:0]  owner;

    modport master (
        input  HLDA, cpuAddr, cpuRead, cpuWrite,
        input  vidReq, vidAddr,
        input  blitReq, blitAddr, blitRead, blitWrite, blitWord,
        output HOLD, vidGnt, blitGnt,
        output ABus, Read, Write, Word, owner
    );

    modport slave (
        output HLDA, cpuAddr, cpuRead, cpuWrite,
        output vidReq, vidAddr,
        output blitReq, blitAddr, blitRead, blitWrite, blitWord,
        input  HOLD, vidGnt, blitGnt,
        input  ABus, Read, Write, Word, owner
    );
endinterface

// File: rtl/m_bus_arbiter.sv
// RAM bus arbiter: takes the bus from the CPU via HOLD/HLDA and shares it between
// video (priority) and a burst-limited blitter. Ports: FCLK, RESET (sync, high), bus.
module m_bus_arbiter #(
    parameter int BLIT_BURST = 16,
    parameter int CPU_GAP    = 4
) (
    input logic             FCLK,
    input logic             RESET,
    m_bus_arbiter_if.master bus
);
    localparam int CW = $clog2(BLIT_BURST + 1);
    localparam int GW = (CPU_GAP > 1) ? $clog2(CPU_GAP) : 1;
    localparam logic [CW-1:0] BURST_C  = CW'(BLIT_BURST);
    localparam logic [GW-1:0] GAP_LAST = GW'(CPU_GAP - 1);

    localparam logic [1:0] OWN_CPU  = 2'b00;
    localparam logic [1:0] OWN_VID  = 2'b01;
    localparam logic [1:0] OWN_BLIT = 2'b10;

    typedef enum logic [2:0] {
        IDLE, HOLDWAIT, VIDEO, BLIT, RELEASE, GAP
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] bcnt, bcnt_nx, bcnt_inc;
    logic [GW-1:0] gcnt, gcnt_nx;
    logic          armed, armed_nx;
    logic          hold_q, hold_nx;
    logic          vgnt_q, vgnt_nx;
    logic          bgnt_q, bgnt_nx;
    logic [1:0]    own_q, own_nx;

    always_ff @(posedge FCLK) begin
        if (RESET) begin
            state  <= IDLE;
            bcnt   <= '0;
            gcnt   <= '0;
            armed  <= 1'b0;
            hold_q <= 1'b0;
            vgnt_q <= 1'b0;
            bgnt_q <= 1'b0;
            own_q  <= OWN_CPU;
        end else begin
            state  <= state_nx;
            bcnt   <= bcnt_nx;
            gcnt   <= gcnt_nx;
            armed  <= armed_nx;
            hold_q <= hold_nx;
            vgnt_q <= vgnt_nx;
            bgnt_q <= bgnt_nx;
            own_q  <= own_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        gcnt_nx  = gcnt;
        armed_nx = armed;
        bcnt_inc = bcnt;
        // Burst count including the grant cycle now ending
        if (bus.blitReq && bcnt != BURST_C)
            bcnt_inc = bcnt + CW'(1);

        case (state)
            IDLE: begin
                if (bus.vidReq || (bus.blitReq && !armed))
                    state_nx = HOLDWAIT;
            end
            HOLDWAIT: begin
                if (bus.HLDA) begin
                    if (bus.vidReq)       state_nx = VIDEO;
                    else if (bus.blitReq) state_nx = BLIT;
                    else                  state_nx = RELEASE;
                end
            end
            VIDEO: begin
                if (!bus.HLDA)
                    state_nx = HOLDWAIT;
                else if (!bus.vidReq) begin
                    if (bus.blitReq && bcnt < BURST_C) state_nx = BLIT;
                    else                               state_nx = RELEASE;
                end
            end
            BLIT: begin
                bcnt_nx = bcnt_inc;
                if (!bus.HLDA)
                    state_nx = HOLDWAIT;
                else if (bus.vidReq)
                    state_nx = VIDEO;
                else if (bcnt_inc == BURST_C) begin
                    state_nx = RELEASE;
                    armed_nx = 1'b1;
                end else if (!bus.blitReq)
                    state_nx = RELEASE;
            end
            RELEASE: begin
                if (!bus.HLDA) begin
                    if (armed) begin
                        state_nx = GAP;
                        gcnt_nx  = '0;
                    end else
                        state_nx = IDLE;
                end
            end
            GAP: begin
                // Video is never held off by the CPU gap
                if (bus.vidReq) begin
                    state_nx = HOLDWAIT;
                    armed_nx = 1'b0;
                end else if (gcnt == GAP_LAST) begin
                    state_nx = IDLE;
                    armed_nx = 1'b0;
                end else
                    gcnt_nx = gcnt + GW'(1);
            end
            default: state_nx = IDLE;
        endcase

        // Every new hold tenure starts with a fresh burst allowance
        if (state_nx == HOLDWAIT && state != HOLDWAIT)
            bcnt_nx = '0;
    end

    // Registered outputs are the decode of the state being entered
    always_comb begin
        hold_nx = 1'b0;
        vgnt_nx = 1'b0;
        bgnt_nx = 1'b0;
        own_nx  = OWN_CPU;
        case (state_nx)
            HOLDWAIT: hold_nx = 1'b1;
            VIDEO: begin
                hold_nx = 1'b1;
                vgnt_nx = 1'b1;
                own_nx  = OWN_VID;
            end
            BLIT: begin
                hold_nx = 1'b1;
                bgnt_nx = 1'b1;
                own_nx  = OWN_BLIT;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.ABus  = bus.cpuAddr;
        bus.Read  = bus.cpuRead;
        bus.Write = bus.cpuWrite;
        bus.Word  = 1'b0;
        case (own_q)
            OWN_VID: begin
                bus.ABus  = bus.vidAddr;
                bus.Read  = 1'b1;
                bus.Write = 1'b0;
                bus.Word  = 1'b1;
            end
            OWN_BLIT: begin
                bus.ABus  = bus.blitAddr;
                bus.Read  = bus.blitRead;
                bus.Write = bus.blitWrite;
                bus.Word  = bus.blitWord;
            end
            default: ;
        endcase
    end

    assign bus.HOLD    = hold_q;
    assign bus.vidGnt  = vgnt_q;
    assign bus.blitGnt = bgnt_q;
    assign bus.owner   = own_q;
endmodule

// File: tb/tb_m_bus_arbiter.sv
// Scoreboard bench for m_bus_arbiter: scenario drivers push expected ownership
// runs; a negedge monitor checks runs, grant rules and the RAM mux every cycle.
module tb_m_bus_arbiter;
    localparam int BURST = 16;
    localparam int CGAP  = 4;

    logic FCLK = 1'b0;
    logic RESET;

    m_bus_arbiter_if bus ();

    m_bus_arbiter #(
        .BLIT_BURST (BURST),
        .CPU_GAP    (CGAP)
    ) dut (
        .FCLK  (FCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 FCLK = ~FCLK;

    typedef struct {
        logic [1:0] own;
        int         len;
        bit         adj;
        int         min_gap;
    } run_t;

    run_t       exp_q[$];
    run_t       e_run;
    int         vectors = 0;
    int         errors  = 0;
    int         hlda_d  = 2;
    logic [3:0] hist    = '0;
    bit         mon_en  = 1'b0;
    logic [1:0] cur_own = 2'b00;
    int         cur_len = 0;
    int         low_cnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_ge(string name, int act, int req);
        vectors++;
        if (act < req) begin
            errors++;
            $display("FAIL %s: got %0d, required at least %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(string name);
        vectors++;
        errors++;
        $display("FAIL %s: got timeout/unexpected, required completion at %0t", name, $time);
    endtask

    // CPU model: HLDA follows HOLD after hlda_d cycles
    initial begin
        bus.HLDA = 1'b0;
        forever begin
            @(posedge FCLK);
            #1;
            hist = {hist[2:0], bus.HOLD};
            bus.HLDA = hist[hlda_d];
        end
    end

    // Random address/strobe traffic from every master
    initial begin
        forever begin
            @(posedge FCLK);
            #1;
            bus.cpuAddr   = 20'($urandom);
            bus.vidAddr   = 20'($urandom);
            bus.blitAddr  = 20'($urandom);
            bus.cpuRead   = 1'($urandom);
            bus.cpuWrite  = 1'($urandom);
            bus.blitRead  = 1'($urandom);
            bus.blitWrite = 1'($urandom);
            bus.blitWord  = 1'($urandom);
        end
    end

    // Monitor
    always @(negedge FCLK) begin
        if (mon_en) begin
            logic [19:0] ea;
            logic [2:0]  es;
            check("gnt_excl", {31'd0, bus.vidGnt & bus.blitGnt}, 0);
            if (bus.vidGnt || bus.blitGnt)
                check("gnt_hlda", {31'd0, bus.HLDA}, 1);
            check("own_vid", {31'd0, bus.owner == 2'b01}, {31'd0, bus.vidGnt});
            check("own_blit", {31'd0, bus.owner == 2'b10}, {31'd0, bus.blitGnt});
            check("own_legal", {31'd0, bus.owner == 2'b11}, 0);
            if (bus.owner == 2'b01) begin
                ea = bus.vidAddr;
                es = 3'b101;
            end else if (bus.owner == 2'b10) begin
                ea = bus.blitAddr;
                es = {bus.blitRead, bus.blitWrite, bus.blitWord};
            end else begin
                ea = bus.cpuAddr;
                es = {bus.cpuRead, bus.cpuWrite, 1'b0};
            end
            check("mux_addr", {12'd0, bus.ABus}, {12'd0, ea});
            check("mux_strb", {29'd0, bus.Read, bus.Write, bus.Word}, {29'd0, es});

            if (bus.owner != cur_own) begin
                if (cur_own != 2'b00) begin
                    if (exp_q.size() > 0) begin
                        e_run = exp_q.pop_front();
                        check("run_len", cur_len, e_run.len);
                    end
                    low_cnt = 0;
                end
                if (bus.owner != 2'b00) begin
                    if (exp_q.size() == 0)
                        fail_now("unexpected_run");
                    else begin
                        check("run_own", {30'd0, bus.owner}, {30'd0, exp_q[0].own});
                        check("run_adj", {31'd0, cur_own != 2'b00}, {31'd0, exp_q[0].adj});
                        if (exp_q[0].min_gap > 0)
                            check_ge("run_gap", low_cnt, exp_q[0].min_gap);
                    end
                end
                cur_own = bus.owner;
                cur_len = 0;
            end
            if (bus.owner != 2'b00) cur_len++;
            if (!bus.HOLD) low_cnt++;
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge FCLK);
            #1;
        end
    endtask

    task automatic quiesce();
        bus.vidReq  = 1'b0;
        bus.blitReq = 1'b0;
        cyc(CGAP + 14);
        check("quiet_hold", {31'd0, bus.HOLD}, 0);
        check("quiet_own", {30'd0, bus.owner}, 0);
        check("quiet_q", exp_q.size(), 0);
    endtask

    task automatic scen_video(int d, int len);
        int t = 0, vc = 0, hl = -1, gl = -1;
        hlda_d = d;
        exp_q.push_back('{2'b01, len, 1'b0, 0});
        bus.vidReq = 1'b1;
        while (vc < len && t < 300) begin
            cyc(1);
            t++;
            if (bus.HOLD && hl < 0) hl = t;
            if (bus.vidGnt) begin
                if (gl < 0) gl = t;
                vc++;
            end
            if (vc == len) bus.vidReq = 1'b0;
        end
        if (vc < len) fail_now("video_timeout");
        check("hold_lat", hl, 1);
        check("vgnt_lat", gl, d + 2);
        quiesce();
    endtask

    task automatic scen_blit(int d, int len);
        int t = 0, bc = 0, rem = len, n;
        bit first = 1'b1;
        hlda_d = d;
        while (rem > 0) begin
            n = (rem > BURST) ? BURST : rem;
            exp_q.push_back('{2'b10, n, 1'b0, first ? 0 : CGAP + 1});
            rem -= n;
            first = 1'b0;
        end
        bus.blitReq = 1'b1;
        while (bc < len && t < 800) begin
            cyc(1);
            t++;
            if (bus.blitGnt) bc++;
            if (bc == len) bus.blitReq = 1'b0;
        end
        if (bc < len) fail_now("blit_timeout");
        quiesce();
    endtask

    task automatic scen_preempt(int d, int p, int lv, int extra);
        int t = 0, bc = 0, vc = 0, total = BURST + extra;
        bit vs = 1'b0, vd = 1'b0;
        hlda_d = d;
        exp_q.push_back('{2'b10, p, 1'b0, 0});
        exp_q.push_back('{2'b01, lv, 1'b1, 0});
        exp_q.push_back('{2'b10, BURST - p, 1'b1, 0});
        exp_q.push_back('{2'b10, extra, 1'b0, CGAP + 1});
        bus.blitReq = 1'b1;
        while ((bc < total || !vd) && t < 800) begin
            cyc(1);
            t++;
            if (bus.blitGnt) bc++;
            if (bus.vidGnt) vc++;
            if (bc == p && !vs) begin
                bus.vidReq = 1'b1;
                vs = 1'b1;
            end
            if (vs && !vd && vc == lv) begin
                bus.vidReq = 1'b0;
                vd = 1'b1;
            end
            if (bc == total) bus.blitReq = 1'b0;
        end
        if (bc < total || !vd) fail_now("preempt_timeout");
        quiesce();
    endtask

    task automatic scen_both(int d, int lv, int lb);
        int t = 0, bc = 0, vc = 0;
        hlda_d = d;
        exp_q.push_back('{2'b01, lv, 1'b0, 0});
        exp_q.push_back('{2'b10, lb, 1'b1, 0});
        bus.vidReq  = 1'b1;
        bus.blitReq = 1'b1;
        while ((bus.vidReq || bus.blitReq) && t < 400) begin
            cyc(1);
            t++;
            if (bus.vidGnt) vc++;
            if (bus.blitGnt) bc++;
            if (vc == lv) bus.vidReq = 1'b0;
            if (bc == lb) bus.blitReq = 1'b0;
        end
        if (bus.vidReq || bus.blitReq) fail_now("both_timeout");
        quiesce();
    endtask

    task automatic scen_withdraw(int d);
        bit seen;
        hlda_d = d;
        bus.blitReq = 1'b1;
        cyc(1);
        bus.blitReq = 1'b0;
        seen = bus.HOLD;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc(1);
            seen = bus.HOLD;
        end
        check("withdraw_hold", {31'd0, seen}, 1);
        quiesce();
    endtask

    task automatic scen_reset(int d, int p);
        int t = 0, bc = 0;
        hlda_d = d;
        exp_q.push_back('{2'b10, p, 1'b0, 0});
        bus.blitReq = 1'b1;
        while (bc < p && t < 300) begin
            cyc(1);
            t++;
            if (bus.blitGnt) bc++;
        end
        if (bc < p) fail_now("reset_timeout");
        RESET = 1'b1;
        cyc(1);
        check("rst_hold", {31'd0, bus.HOLD}, 0);
        check("rst_bgnt", {31'd0, bus.blitGnt}, 0);
        check("rst_own", {30'd0, bus.owner}, 0);
        RESET = 1'b0;
        quiesce();
    endtask

    initial begin
        RESET         = 1'b1;
        bus.vidReq    = 1'b0;
        bus.blitReq   = 1'b0;
        bus.cpuAddr   = '0;
        bus.vidAddr   = '0;
        bus.blitAddr  = '0;
        bus.cpuRead   = 1'b0;
        bus.cpuWrite  = 1'b0;
        bus.blitRead  = 1'b0;
        bus.blitWrite = 1'b0;
        bus.blitWord  = 1'b0;
        cyc(3);
        check("reset_hold", {31'd0, bus.HOLD}, 0);
        check("reset_vgnt", {31'd0, bus.vidGnt}, 0);
        check("reset_bgnt", {31'd0, bus.blitGnt}, 0);
        check("reset_own", {30'd0, bus.owner}, 0);
        RESET  = 1'b0;
        mon_en = 1'b1;
        cyc(8);

        scen_video(2, 8);
        scen_blit(2, 2 * BURST + 3);
        scen_preempt(2, 5, 6, 4);
        scen_both(2, 6, 10);
        scen_withdraw(2);
        scen_reset(2, 7);

        for (int i = 0; i < 40; i++) begin
            int d;
            d = $urandom_range(1, 3);
            case ($urandom_range(0, 5))
                0: scen_video(d, $urandom_range(1, 10));
                1: scen_blit(d, $urandom_range(1, 40));
                2: scen_preempt(d, $urandom_range(1, BURST - 1),
                                $urandom_range(1, 8), $urandom_range(1, 8));
                3: scen_both(d, $urandom_range(1, 8), $urandom_range(1, BURST));
                4: scen_withdraw(d);
                default: scen_reset(d, $urandom_range(1, BURST - 1));
            endcase
        end

        check("final_q", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
